matrix_deskewer: RTL and testbench
==================================

// Module: matrix_deskewer
// PURPOSE
//  Inverse of the diagonal skew feeder. Accepts one skewed wavefront vector per valid cycle from
//  the systolic array output edge and reassembles the N x N result matrix in a register buffer.
//  Wavefront step s carries lane i = M[i][s-i]. Lanes with s-i outside 0..N-1 are don't-care.
//  Sits between the systolic array and the result readout or host interface.
// PARAMETERS
//  N   32   matrix dimension; wavefront vector width in lanes
//  W   16   element width in bits
// PORTS
//  clk            in   1          single clock, rising edge
//  rst_n          in   1          asynchronous active-low reset
//  start          in   1          begin a new collection; single-cycle pulse
//  in_valid       in   1          vector_in holds the current wavefront step
//  vector_in      in   W x [0:N-1]  skewed wavefront, lane i
//  matrix_out     out  W x [0:N-1][0:N-1]  reassembled matrix [row][col]
//  busy           out  1          collection in progress
//  done           out  1          one-cycle pulse after the final step is captured
//  matrix_valid   out  1          matrix_out is complete and stable
//  step_dbg       out  8          current step counter, for debug
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=IDLE; step=0
//   - every matrix_out element = 0
//   - busy=0, done=0, matrix_valid=0
//  States: IDLE, COLLECT, HOLD.
//  IDLE:
//   - start=1 -> COLLECT; step<=0; matrix_valid<=0
//   - in_valid is ignored
//  COLLECT (busy=1):
//   - Each clk with in_valid=1: for every lane i, j=step-i.
//   - If 0<=j<N: matrix_out[i][j] <= vector_in[i]. Other lanes are dropped.
//   - step<=step+1.
//   - in_valid=0: hold; no write; step unchanged. Bubbles are allowed anywhere.
//   - Capture at step==2N-2 (62 for N=32) is the last one.
//     Same edge: -> HOLD; done<=1 for one cycle; matrix_valid<=1; busy<=0.
//   - start=1 in COLLECT restarts: step<=0. Same-cycle in_valid is ignored. Buffer is not
//     cleared, because a full pass overwrites every cell.
//  HOLD:
//   - matrix_out is frozen; in_valid is ignored.
//   - start=1 -> COLLECT as from IDLE; matrix_valid drops on the next edge.
//  Latency: the last write appears on matrix_out in the same cycle done is high.
//   - A gapless pass takes 2N-1 valid cycles; done is seen on cycle 2N after start.
//  Widths:
//   - step is 8 bits and never exceeds 2N-2; 2N-2 must fit in 8 bits (N<=128).
//   - j is computed signed or with a guard, so that step<i never writes.
//  Each cell is written on exactly one step (s=i+j). No write conflicts exist.
//  done and start in the same cycle (from HOLD): start wins; next state is COLLECT.
//  Reset mid-COLLECT: asynchronously returns to IDLE and zeroes the buffer.
// TESTING
//  1. Reset, then start, then 63 gapless steps with lane i = 100*i + (s-i).
//     -> matrix_out[i][j] == 100*i+j for all i,j; done pulses once; matrix_valid=1.
//  2. Same as scenario 1, with in_valid deasserted every third cycle.
//     -> identical matrix; done is delayed by the bubble count; step_dbg holds during bubbles.
//  3. Out-of-range lanes driven to 16'hDEAD (e.g. s=0, lanes 1..31).
//     -> no cell ever equals 16'hDEAD.
//  4. start at step 20 with data set A, then a full pass with data set B.
//     -> matrix_out equals B everywhere; exactly one done pulse.
//  5. rst_n low at step 40.
//     -> all outputs are 0 immediately (async); IDLE; in_valid is ignored until the next start.
//  6. In HOLD, drive in_valid with random data for 10 cycles.
//     -> matrix_out is unchanged; matrix_valid stays 1; done stays 0.

Source files
------------

// File: rtl/matrix_deskewer_if.sv
// Handshake and result bundle for the wavefront deskewer.
// master drives stimulus; slave is the deskewer itself.
interface matrix_deskewer_if #(
    parameter int N = 32,
    parameter int W = 16
);
    logic                             start;
    logic                             in_valid;
    logic [0:N-1][W-1:0]              vector_in;
    logic [0:N-1][0:N-1][W-1:0]       matrix_out;
    logic                             busy;
    logic                             done;
    logic                             matrix_valid;
    logic [7:0]                       step_dbg;

    modport master (
        output start, in_valid, vector_in,
        input  matrix_out, busy, done, matrix_valid, step_dbg
    );

    modport slave (
        input  start, in_valid, vector_in,
        output matrix_out, busy, done, matrix_valid, step_dbg
    );
endinterface

// File: rtl/matrix_deskewer.sv
// Reassembles an N x N matrix from skewed systolic wavefronts.
// Step s carries lane i = M[i][s-i]; out-of-range lanes are dropped.
module matrix_deskewer #(
    parameter int N = 32,
    parameter int W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    matrix_deskewer_if.slave io
);
    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    localparam logic [7:0] LAST_STEP = 8'(2 * N - 2);

    state_t                         state_q, state_d;
    logic [7:0]                     step_q, step_d;
    logic [0:N-1][0:N-1][W-1:0]     mat_q, mat_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           mv_q, mv_d;

    // Next-state, step counter and cell capture for one wavefront step
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        mat_d   = mat_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mv_d    = mv_q;
        unique case (state_q)
            IDLE, HOLD: begin
                if (io.start) begin
                    state_d = COLLECT;
                    step_d  = 8'd0;
                    busy_d  = 1'b1;
                    mv_d    = 1'b0;
                end
            end
            COLLECT: begin
                if (io.start) begin
                    // restart; a full pass rewrites every cell
                    step_d = 8'd0;
                end else if (io.in_valid) begin
                    // cell (i,j) lives on step i+j, so step<i never matches
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            if (int'(step_q) == i + j) begin
                                mat_d[i][j] = io.vector_in[i];
                            end
                        end
                    end
                    if (step_q == LAST_STEP) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                        mv_d    = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        step_d = step_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and registered outputs; reset clears the buffer too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 8'd0;
            mat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            mat_q   <= mat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mv_q    <= mv_d;
        end
    end

    assign io.matrix_out   = mat_q;
    assign io.busy         = busy_q;
    assign io.done         = done_q;
    assign io.matrix_valid = mv_q;
    assign io.step_dbg     = step_q;
endmodule

// File: tb/tb_matrix_deskewer.sv
// Directed bench for matrix_deskewer with an expected-matrix scoreboard.
// Expected matrices are queued at pass start and popped on done.
module tb_matrix_deskewer;
    localparam int N = 32;
    localparam int W = 16;
    localparam int LAST = 2 * N - 2;

    typedef logic [0:N-1][0:N-1][W-1:0] mat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    mat_t sb[$];

    matrix_deskewer_if #(.N(N), .W(W)) io ();

    matrix_deskewer #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (io.done) done_cnt++;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mat(string tag, mat_t obs, mat_t exp);
        int fi = 0;
        int fj = 0;
        bit found = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (!found && obs[i][j] !== exp[i][j]) begin
                    found = 1;
                    fi = i;
                    fj = j;
                end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: cell[%0d][%0d] got %0h want %0h",
                   tag, fi, fj, obs[fi][fj], exp[fi][fj]);
        end
    endtask

    function automatic mat_t model(int off);
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = W'(off + 100 * i + j);
        return m;
    endfunction

    task automatic drive_step(int off, int s);
        for (int i = 0; i < N; i++) begin
            if (s - i >= 0 && s - i < N)
                io.vector_in[i] = W'(off + 100 * i + (s - i));
            else
                io.vector_in[i] = 16'hDEAD;
        end
    endtask

    // start, then nsteps valid steps with a bubble every gap-th cycle
    task automatic run_pass(int off, int gap, int nsteps, bit full);
        int cyc = 0;
        mat_t e;
        if (full) begin
            e = model(off);
            sb.push_back(e);
        end
        io.start = 1'b1;
        io.in_valid = 1'b1;
        drive_step(off + 333, 0);
        tick();
        io.start = 1'b0;
        chk("start_busy", 32'(io.busy), 32'd1);
        chk("start_mv", 32'(io.matrix_valid), 32'd0);
        chk("start_done", 32'(io.done), 32'd0);
        chk("start_step", 32'(io.step_dbg), 32'd0);
        for (int s = 0; s < nsteps; s++) begin
            if (gap > 0 && (cyc % gap) == gap - 1) begin
                io.in_valid = 1'b0;
                for (int i = 0; i < N; i++) io.vector_in[i] = W'($urandom);
                tick();
                cyc++;
                chk("bubble_step", 32'(io.step_dbg), 32'(s));
            end
            io.in_valid = 1'b1;
            drive_step(off, s);
            tick();
            cyc++;
            if (s < LAST) begin
                chk("mid_done", 32'(io.done), 32'd0);
                chk("mid_step", 32'(io.step_dbg), 32'(s + 1));
            end
        end
        io.in_valid = 1'b0;
        if (full) begin
            chk("end_done", 32'(io.done), 32'd1);
            chk("end_busy", 32'(io.busy), 32'd0);
            chk("end_mv", 32'(io.matrix_valid), 32'd1);
            chk("end_step", 32'(io.step_dbg), 32'(LAST));
            if (io.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_empty: got done want no output");
                end else begin
                    e = sb.pop_front();
                    chk_mat("matrix", io.matrix_out, e);
                end
            end
        end
    endtask

    initial begin
        int dead;
        mat_t zero;
        zero = '0;
        io.start = 1'b0;
        io.in_valid = 1'b0;
        io.vector_in = '0;
        #12;
        chk("rst_busy", 32'(io.busy), 32'd0);
        chk("rst_done", 32'(io.done), 32'd0);
        chk("rst_mv", 32'(io.matrix_valid), 32'd0);
        chk("rst_step", 32'(io.step_dbg), 32'd0);
        chk_mat("rst_matrix", io.matrix_out, zero);
        rst_n = 1'b1;
        io.in_valid = 1'b1;
        drive_step(9000, 0);
        tick();
        tick();
        chk("idle_ignore", 32'(io.step_dbg), 32'd0);
        chk_mat("idle_matrix", io.matrix_out, zero);

        // gapless pass, out-of-range lanes carry DEAD
        run_pass(0, 0, LAST + 1, 1);
        dead = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (io.matrix_out[i][j] === 16'hDEAD) dead++;
        chk("dead_cells", 32'(dead), 32'd0);

        // start lands on the done cycle; bubbles every third cycle
        run_pass(0, 3, LAST + 1, 1);
        tick();
        chk("done_pulse", 32'(io.done), 32'd0);

        // HOLD ignores in_valid
        for (int k = 0; k < 10; k++) begin
            io.in_valid = 1'b1;
            for (int i = 0; i < N; i++) io.vector_in[i] = W'($urandom);
            tick();
            chk("hold_mv", 32'(io.matrix_valid), 32'd1);
            chk("hold_done", 32'(io.done), 32'd0);
        end
        io.in_valid = 1'b0;
        chk_mat("hold_matrix", io.matrix_out, model(0));

        // restart mid-pass with set A, then full pass with set B
        done_cnt = 0;
        run_pass(7000, 0, 20, 0);
        run_pass(20000, 0, LAST + 1, 1);
        tick();
        chk("restart_dones", 32'(done_cnt), 32'd1);

        // async reset mid-collection
        run_pass(3000, 0, 40, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(io.busy), 32'd0);
        chk("arst_step", 32'(io.step_dbg), 32'd0);
        chk("arst_mv", 32'(io.matrix_valid), 32'd0);
        chk_mat("arst_matrix", io.matrix_out, zero);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            io.in_valid = 1'b1;
            drive_step(4000, k);
            tick();
        end
        io.in_valid = 1'b0;
        chk("post_step", 32'(io.step_dbg), 32'd0);
        chk("post_busy", 32'(io.busy), 32'd0);
        chk_mat("post_matrix", io.matrix_out, zero);
        chk("sb_left", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
